// File: rtl/imuldiv_mul_div_dispatch_if.sv
// ----------------------------------------------------------------------------
// imuldiv_mul_div_dispatch_if
//
// Bundles every handshake bus around the mul/div dispatcher:
//   muldivreq_*  : client request  (fn, a, b, val/rdy)
//   muldivresp_* : client response (result, val/rdy)
//   mulreq_*     : request to the multiplier unit
//   mulresp_*    : 64-bit product from the multiplier unit
//   divreq_*     : request to the divider unit (fn: 0 signed, 1 unsigned)
//   divresp_*    : {remainder, quotient} from the divider unit
//
// Modports:
//   slave  - the dispatcher's view (serves the client, drives the units)
//   master - the surrounding environment's view (client plus both units)
// ----------------------------------------------------------------------------
interface imuldiv_mul_div_dispatch_if;

   logic [2:0]  muldivreq_msg_fn;
   logic [31:0] muldivreq_msg_a;
   logic [31:0] muldivreq_msg_b;
   logic        muldivreq_val;
   logic        muldivreq_rdy;

   logic [31:0] muldivresp_msg_result;
   logic        muldivresp_val;
   logic        muldivresp_rdy;

   logic [31:0] mulreq_msg_a;
   logic [31:0] mulreq_msg_b;
   logic        mulreq_val;
   logic        mulreq_rdy;

   logic [63:0] mulresp_msg_result;
   logic        mulresp_val;
   logic        mulresp_rdy;

   logic        divreq_msg_fn;
   logic [31:0] divreq_msg_a;
   logic [31:0] divreq_msg_b;
   logic        divreq_val;
   logic        divreq_rdy;

   logic [63:0] divresp_msg_result;
   logic        divresp_val;
   logic        divresp_rdy;

   modport slave (
      input  muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_val,
      output muldivreq_rdy,
      output muldivresp_msg_result, muldivresp_val,
      input  muldivresp_rdy,
      output mulreq_msg_a, mulreq_msg_b, mulreq_val,
      input  mulreq_rdy,
      input  mulresp_msg_result, mulresp_val,
      output mulresp_rdy,
      output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
      input  divreq_rdy,
      input  divresp_msg_result, divresp_val,
      output divresp_rdy
   );

   modport master (
      output muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_val,
      input  muldivreq_rdy,
      input  muldivresp_msg_result, muldivresp_val,
      output muldivresp_rdy,
      input  mulreq_msg_a, mulreq_msg_b, mulreq_val,
      output mulreq_rdy,
      output mulresp_msg_result, mulresp_val,
      input  mulresp_rdy,
      input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
      output divreq_rdy,
      output divresp_msg_result, divresp_val,
      input  divresp_rdy
   );

endinterface

// File: rtl/imuldiv_mul_div_dispatch.sv
// ----------------------------------------------------------------------------
// imuldiv_mul_div_dispatch
//
// Accepts one mul/div/rem request at a time, forwards it to the multiplier or
// divider unit, collects that unit's answer, selects the 32-bit result and
// returns it to the client. Exactly one operation is outstanding at any time.
//
// fn encoding: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU; 5-7 are illegal and are
// answered immediately with a zero result without touching either unit.
//
// Ports:
//   clk   - single clock, all state changes on its rising edge
//   reset - asynchronous, active-high; abandons any operation in flight
//   bus   - all request/response handshakes (see imuldiv_mul_div_dispatch_if)
//
// Every output is decoded from registered state only, so no input reaches an
// output combinationally.
// ----------------------------------------------------------------------------
module imuldiv_mul_div_dispatch (
   input logic                           clk,
   input logic                           reset,
   imuldiv_mul_div_dispatch_if.slave     bus
);

   typedef enum logic [2:0] {
      IDLE,
      REQ_MUL,
      REQ_DIV,
      WAIT_MUL,
      WAIT_DIV,
      RESP
   } state_t;

   localparam logic [2:0] FN_MUL  = 3'd0;
   localparam logic [2:0] FN_DIVU = 3'd2;
   localparam logic [2:0] FN_REM  = 3'd3;
   localparam logic [2:0] FN_REMU = 3'd4;

   state_t      state;
   state_t      state_nxt;

   logic [2:0]  fn_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] result_q;

   logic        accept;
   logic        fn_is_rem;
   logic        fn_is_unsigned;

   // Only the low product word and the selected divider half are ever used;
   // the high product word is folded here so it is visibly consumed.
   logic        unused_mul_hi;
   assign unused_mul_hi = ^bus.mulresp_msg_result[63:32];

   assign accept         = (state == IDLE) && bus.muldivreq_val;
   assign fn_is_rem      = (fn_q == FN_REM)  || (fn_q == FN_REMU);
   assign fn_is_unsigned = (fn_q == FN_DIVU) || (fn_q == FN_REMU);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Operand and result registers. Operands move only on an IDLE accept, which
   // keeps the unit request fields stable until the unit takes them.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fn_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else begin
         if (accept) begin
            fn_q <= bus.muldivreq_msg_fn;
            a_q  <= bus.muldivreq_msg_a;
            b_q  <= bus.muldivreq_msg_b;
            // Illegal functions skip the units and answer with zero.
            if (bus.muldivreq_msg_fn > FN_REMU) begin
               result_q <= '0;
            end
         end
         if ((state == WAIT_MUL) && bus.mulresp_val) begin
            result_q <= bus.mulresp_msg_result[31:0];
         end
         if ((state == WAIT_DIV) && bus.divresp_val) begin
            result_q <= fn_is_rem ? bus.divresp_msg_result[63:32]
                                  : bus.divresp_msg_result[31:0];
         end
      end
   end

   assign bus.muldivresp_msg_result = result_q;

   // -------------------------------------------------------------------------
   // Next-state and Moore output decode
   // -------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_nxt          = state;
      bus.muldivreq_rdy  = 1'b0;
      bus.muldivresp_val = 1'b0;
      bus.mulreq_val     = 1'b0;
      bus.mulreq_msg_a   = '0;
      bus.mulreq_msg_b   = '0;
      bus.mulresp_rdy    = 1'b0;
      bus.divreq_val     = 1'b0;
      bus.divreq_msg_fn  = 1'b0;
      bus.divreq_msg_a   = '0;
      bus.divreq_msg_b   = '0;
      bus.divresp_rdy    = 1'b0;

      case (state)
         IDLE: begin
            bus.muldivreq_rdy = 1'b1;
            if (bus.muldivreq_val) begin
               if (bus.muldivreq_msg_fn == FN_MUL) begin
                  state_nxt = REQ_MUL;
               end else if (bus.muldivreq_msg_fn <= FN_REMU) begin
                  state_nxt = REQ_DIV;
               end else begin
                  state_nxt = RESP;
               end
            end
         end

         REQ_MUL: begin
            bus.mulreq_val   = 1'b1;
            bus.mulreq_msg_a = a_q;
            bus.mulreq_msg_b = b_q;
            if (bus.mulreq_rdy) begin
               state_nxt = WAIT_MUL;
            end
         end

         REQ_DIV: begin
            bus.divreq_val    = 1'b1;
            bus.divreq_msg_fn = fn_is_unsigned;
            bus.divreq_msg_a  = a_q;
            bus.divreq_msg_b  = b_q;
            if (bus.divreq_rdy) begin
               state_nxt = WAIT_DIV;
            end
         end

         WAIT_MUL: begin
            bus.mulresp_rdy = 1'b1;
            if (bus.mulresp_val) begin
               state_nxt = RESP;
            end
         end

         WAIT_DIV: begin
            bus.divresp_rdy = 1'b1;
            if (bus.divresp_val) begin
               state_nxt = RESP;
            end
         end

         RESP: begin
            bus.muldivresp_val = 1'b1;
            if (bus.muldivresp_rdy) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_imuldiv_mul_div_dispatch.sv
// ----------------------------------------------------------------------------
// tb_imuldiv_mul_div_dispatch
//
// Self-checking bench for imuldiv_mul_div_dispatch. The bench plays the
// client and both arithmetic units. Expected results come from a reference
// function computing each operation with plain arithmetic; unit answers come
// from a separate unit model that produces the full 64-bit response words.
// ----------------------------------------------------------------------------
module tb_imuldiv_mul_div_dispatch;

   logic clk;
   logic reset;

   int n_cmp;
   int n_err;

   imuldiv_mul_div_dispatch_if bus ();

   imuldiv_mul_div_dispatch dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // --------------------------------------------------------------------------
   // Reference: the 32-bit answer the client must receive for (fn, a, b).
   // --------------------------------------------------------------------------
   function automatic logic [31:0] ref_result(input logic [2:0] fn,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic [31:0] p;
      case (fn)
         3'd0:    begin p = a * b; return p; end
         3'd1:    return $signed(a) / $signed(b);
         3'd2:    return a / b;
         3'd3:    return $signed(a) % $signed(b);
         3'd4:    return a % b;
         default: return 32'h0;
      endcase
   endfunction

   // Unit model: 64-bit product, or {remainder, quotient} from the divider.
   function automatic logic [63:0] unit_model(input logic [2:0] fn,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic [31:0]        q;
      logic [31:0]        r;
      if (fn == 3'd0) begin
         sa = $signed({{32{a[31]}}, a});
         sb = $signed({{32{b[31]}}, b});
         return sa * sb;
      end
      if (fn == 3'd2 || fn == 3'd4) begin
         q = a / b;
         r = a % b;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
      return {r, q};
   endfunction

   // Keeps a new (never to be accepted) request on the client bus while the
   // dispatcher is busy.
   task automatic scramble_req();
      bus.muldivreq_msg_fn = 3'($urandom);
      bus.muldivreq_msg_a  = $urandom;
      bus.muldivreq_msg_b  = $urandom;
   endtask

   // --------------------------------------------------------------------------
   // One full transaction, starting at a negedge with the DUT idle.
   // req_dly : cycles the unit keeps its req_rdy low
   // resp_dly: cycles between unit acceptance and its response
   // out_dly : cycles the client keeps muldivresp_rdy low
   // --------------------------------------------------------------------------
   task automatic do_txn(input string       name,
                         input logic [2:0]  fn,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [63:0] unit_res,
                         input logic [31:0] exp,
                         input int          req_dly,
                         input int          resp_dly,
                         input int          out_dly);
      bit          is_mul;
      bit          illegal;
      logic        exp_fn;
      int          lat;
      int          exp_lat;
      logic [68:0] obs_r;
      logic [68:0] exp_r;
      logic [3:0]  obs_w;
      logic [37:0] obs_o;
      logic [37:0] exp_o;
      logic [1:0]  obs_i;

      is_mul  = (fn == 3'd0);
      illegal = (fn > 3'd4);
      exp_fn  = (!is_mul) && (fn == 3'd2 || fn == 3'd4);
      exp_lat = illegal ? 1 : 3 + req_dly + resp_dly;

      n_cmp++;
      if (bus.muldivreq_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL %s start_rdy: got %b want 1", name, bus.muldivreq_rdy);
      end

      bus.muldivreq_val    = 1'b1;
      bus.muldivreq_msg_fn = fn;
      bus.muldivreq_msg_a  = a;
      bus.muldivreq_msg_b  = b;
      @(negedge clk);
      lat = 1;
      scramble_req();

      if (!illegal) begin
         // Request phase; a stray response from the same unit must be ignored.
         for (int i = 0; i <= req_dly; i++) begin
            if (is_mul)
               obs_r = {bus.mulreq_val, bus.divreq_val, bus.mulreq_msg_a,
                        bus.mulreq_msg_b, bus.divreq_msg_fn,
                        bus.muldivreq_rdy, bus.muldivresp_val};
            else
               obs_r = {bus.divreq_val, bus.mulreq_val, bus.divreq_msg_a,
                        bus.divreq_msg_b, bus.divreq_msg_fn,
                        bus.muldivreq_rdy, bus.muldivresp_val};
            exp_r = {1'b1, 1'b0, a, b, exp_fn, 1'b0, 1'b0};
            n_cmp++;
            if (obs_r !== exp_r) begin
               n_err++;
               $display("FAIL %s unit_req[%0d]: got %h want %h", name, i, obs_r, exp_r);
            end
            if (is_mul) begin
               bus.mulreq_rdy         = (i == req_dly);
               bus.mulresp_val        = 1'b1;
               bus.mulresp_msg_result = {$urandom, $urandom};
            end else begin
               bus.divreq_rdy         = (i == req_dly);
               bus.divresp_val        = 1'b1;
               bus.divresp_msg_result = {$urandom, $urandom};
            end
            scramble_req();
            @(negedge clk);
            lat++;
            bus.mulreq_rdy  = 1'b0;
            bus.divreq_rdy  = 1'b0;
            bus.mulresp_val = 1'b0;
            bus.divresp_val = 1'b0;
         end

         // Wait phase; the other unit's stray responses must be ignored.
         for (int i = 0; i <= resp_dly; i++) begin
            if (is_mul)
               obs_w = {bus.mulresp_rdy, bus.divresp_rdy, bus.mulreq_val, bus.muldivresp_val};
            else
               obs_w = {bus.divresp_rdy, bus.mulresp_rdy, bus.divreq_val, bus.muldivresp_val};
            n_cmp++;
            if (obs_w !== 4'b1000) begin
               n_err++;
               $display("FAIL %s unit_wait[%0d]: got %b want 1000", name, i, obs_w);
            end
            if (i == resp_dly) begin
               if (is_mul) begin
                  bus.mulresp_val        = 1'b1;
                  bus.mulresp_msg_result = unit_res;
               end else begin
                  bus.divresp_val        = 1'b1;
                  bus.divresp_msg_result = unit_res;
               end
            end else if (is_mul) begin
               bus.divresp_val        = 1'b1;
               bus.divresp_msg_result = {$urandom, $urandom};
            end else begin
               bus.mulresp_val        = 1'b1;
               bus.mulresp_msg_result = {$urandom, $urandom};
            end
            scramble_req();
            @(negedge clk);
            lat++;
            bus.mulresp_val = 1'b0;
            bus.divresp_val = 1'b0;
         end
      end

      // Response phase; result must hold while the client stalls.
      for (int i = 0; i <= out_dly; i++) begin
         if (i == 0) begin
            n_cmp++;
            if (lat !== exp_lat || bus.muldivresp_val !== 1'b1) begin
               n_err++;
               $display("FAIL %s latency: got %0d cycles (val %b) want %0d", name, lat,
                        bus.muldivresp_val, exp_lat);
            end
         end
         obs_o = {bus.muldivresp_val, bus.muldivreq_rdy, bus.mulreq_val, bus.divreq_val,
                  bus.mulresp_rdy, bus.divresp_rdy, bus.muldivresp_msg_result};
         exp_o = {6'b100000, exp};
         n_cmp++;
         if (obs_o !== exp_o) begin
            n_err++;
            $display("FAIL %s resp[%0d]: got %h want %h", name, i, obs_o, exp_o);
         end
         bus.muldivresp_rdy     = (i == out_dly);
         bus.mulresp_val        = 1'b1;
         bus.divresp_val        = 1'b1;
         bus.mulresp_msg_result = {$urandom, $urandom};
         bus.divresp_msg_result = {$urandom, $urandom};
         scramble_req();
         @(negedge clk);
         bus.muldivresp_rdy = 1'b0;
         bus.mulresp_val    = 1'b0;
         bus.divresp_val    = 1'b0;
      end

      // The request held high through the exit edge must not have been taken.
      bus.muldivreq_val = 1'b0;
      obs_i = {bus.muldivresp_val, bus.muldivreq_rdy};
      n_cmp++;
      if (obs_i !== 2'b01) begin
         n_err++;
         $display("FAIL %s back_to_idle: got %b want 01", name, obs_i);
      end
   endtask

   // --------------------------------------------------------------------------
   // Scenarios
   // --------------------------------------------------------------------------
   task automatic test_reset();
      logic [74:0] obs;
      reset = 1'b1;
      @(negedge clk);
      obs = {bus.muldivresp_val, bus.mulreq_val, bus.divreq_val, bus.mulresp_rdy,
             bus.divresp_rdy, bus.divreq_msg_fn, bus.mulreq_msg_a, bus.divreq_msg_b,
             bus.muldivresp_msg_result[10:0]};
      n_cmp++;
      if (obs !== '0) begin
         n_err++;
         $display("FAIL reset_during: got %h want 0", obs);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.muldivreq_rdy, bus.muldivresp_val, bus.mulreq_val, bus.divreq_val,
           bus.muldivresp_msg_result} !== {4'b1000, 32'h0}) begin
         n_err++;
         $display("FAIL reset_after: got rdy %b rval %b mval %b dval %b res %h want 1 0 0 0 0",
                  bus.muldivreq_rdy, bus.muldivresp_val, bus.mulreq_val, bus.divreq_val,
                  bus.muldivresp_msg_result);
      end
   endtask

   task automatic test_directed();
      do_txn("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB,
             32'hFFFF_FFEB, 0, 0, 0);
      do_txn("div_m7_2", 3'd1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
             32'hFFFF_FFFD, 0, 0, 0);
      do_txn("remu_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
             32'hFFFF_FFFF, 0, 0, 0);
      do_txn("illegal_fn6", 3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0, 32'h0, 0, 0, 0);
   endtask

   task automatic test_stall();
      do_txn("div_stall", 3'd1, 32'd100, 32'd7, unit_model(3'd1, 32'd100, 32'd7),
             ref_result(3'd1, 32'd100, 32'd7), 5, 2, 3);
   endtask

   task automatic test_back_to_back();
      do_txn("b2b_mul", 3'd0, 32'd1234, 32'd5678, unit_model(3'd0, 32'd1234, 32'd5678),
             ref_result(3'd0, 32'd1234, 32'd5678), 0, 0, 0);
      do_txn("b2b_rem", 3'd3, 32'hFFFF_FF00, 32'd17, unit_model(3'd3, 32'hFFFF_FF00, 32'd17),
             ref_result(3'd3, 32'hFFFF_FF00, 32'd17), 0, 0, 0);
   endtask

   task automatic test_random();
      logic [2:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      for (int k = 0; k < 40; k++) begin
         fn = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (k % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if (b == 32'h0) b = 32'd1;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
         do_txn($sformatf("rand%0d_fn%0d", k, fn), fn, a, b, unit_model(fn, a, b),
                ref_result(fn, a, b), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3));
      end
   endtask

   task automatic test_reset_mid();
      logic [70:0] obs;
      logic [2:0]  obs_i;
      bus.muldivreq_val    = 1'b1;
      bus.muldivreq_msg_fn = 3'd1;
      bus.muldivreq_msg_a  = 32'd100;
      bus.muldivreq_msg_b  = 32'd7;
      @(negedge clk);
      bus.muldivreq_val = 1'b0;
      bus.divreq_rdy    = 1'b1;
      @(negedge clk);
      bus.divreq_rdy = 1'b0;
      n_cmp++;
      if (bus.divresp_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid_wait: got divresp_rdy %b want 1", bus.divresp_rdy);
      end
      #2 reset = 1'b1;
      #1;
      obs = {bus.divresp_rdy, bus.divreq_val, bus.mulreq_val, bus.muldivresp_val,
             bus.mulresp_rdy, bus.divreq_msg_fn, bus.divreq_msg_a, bus.muldivresp_msg_result[32-1:0]};
      n_cmp++;
      if (obs !== '0) begin
         n_err++;
         $display("FAIL rst_mid_async: got %h want 0", obs);
      end
      @(negedge clk);
      reset                  = 1'b0;
      bus.divresp_val        = 1'b1;
      bus.divresp_msg_result = {32'd2, 32'd14};
      @(negedge clk);
      bus.divresp_val = 1'b0;
      for (int i = 0; i < 4; i++) begin
         obs_i = {bus.muldivresp_val, bus.divresp_rdy, bus.muldivreq_rdy};
         n_cmp++;
         if (obs_i !== 3'b001) begin
            n_err++;
            $display("FAIL rst_mid_after[%0d]: got %b want 001", i, obs_i);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      n_cmp                  = 0;
      n_err                  = 0;
      reset                  = 1'b1;
      bus.muldivreq_val      = 1'b0;
      bus.muldivreq_msg_fn   = '0;
      bus.muldivreq_msg_a    = '0;
      bus.muldivreq_msg_b    = '0;
      bus.muldivresp_rdy     = 1'b0;
      bus.mulreq_rdy         = 1'b0;
      bus.mulresp_val        = 1'b0;
      bus.mulresp_msg_result = '0;
      bus.divreq_rdy         = 1'b0;
      bus.divresp_val        = 1'b0;
      bus.divresp_msg_result = '0;
      @(negedge clk);

      test_reset();
      test_directed();
      test_stall();
      test_back_to_back();
      test_random();
      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/imuldiv_mul_div_dispatch.md
IMULDIV_MUL_DIV_DISPATCH -- requirements
Module: imuldiv_MulDivDispatch

Interface
REQ-001: Parameters: none; all widths fixed.
REQ-002: clk  in  1  single clock; all state updates on posedge clk.
REQ-003: reset  in  1  asynchronous, active-high reset.
REQ-004: muldivreq_msg_fn  in  3  operation: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU; 5-7 illegal.
REQ-005: muldivreq_msg_a / muldivreq_msg_b  in  32 each  operands A, B.
REQ-006: muldivreq_val  in  1 / muldivreq_rdy  out  1  request handshake.
REQ-007: muldivresp_msg_result  out  32  selected 32-bit result.
REQ-008: muldivresp_val  out  1 / muldivresp_rdy  in  1  response handshake.
REQ-009: mulreq_msg_a / mulreq_msg_b  out  32 each; mulreq_val  out  1; mulreq_rdy  in  1  multiplier request.
REQ-010: mulresp_msg_result  in  64  product; mulresp_val  in  1; mulresp_rdy  out  1.
REQ-011: divreq_msg_fn  out  1  (0 signed, 1 unsigned); divreq_msg_a / divreq_msg_b  out  32 each; divreq_val  out  1; divreq_rdy  in  1.
REQ-012: divresp_msg_result  in  64  {remainder[63:32], quotient[31:0]}; divresp_val  in  1; divresp_rdy  out  1.

Function
REQ-013: States SHALL be IDLE, REQ_MUL, REQ_DIV, WAIT_MUL, WAIT_DIV, RESP; exactly one outstanding operation.
REQ-014: IDLE: muldivreq_rdy=1, all other val/rdy outputs 0.
REQ-015: IDLE and muldivreq_val=1: latch fn, a, b into operand registers same edge; fn 0 -> REQ_MUL, fn 1-4 -> REQ_DIV, fn 5-7 -> RESP with result register loaded to 32'h0 (no unit dispatched).
REQ-016: REQ_MUL: mulreq_val=1, mulreq_msg_a/b from latched operands; on mulreq_rdy=1 -> WAIT_MUL, else hold.
REQ-017: REQ_DIV: divreq_val=1, divreq_msg_fn = 1 for DIVU/REMU, 0 for DIV/REM; on divreq_rdy=1 -> WAIT_DIV, else hold.
REQ-018: WAIT_MUL: mulresp_rdy=1; on mulresp_val=1 load result register with mulresp_msg_result[31:0], -> RESP.
REQ-019: WAIT_DIV: divresp_rdy=1; on divresp_val=1 load [31:0] for DIV/DIVU, [63:32] for REM/REMU, -> RESP.
REQ-020: RESP: muldivresp_val=1, muldivresp_msg_result = result register; on muldivresp_rdy=1 -> IDLE, else hold with result stable.
REQ-021: muldivreq_rdy SHALL be 0 in every state except IDLE; no new request accepted in the RESP-exit cycle.
REQ-022: Unit request outputs SHALL be stable from REQ_x entry until the accepting edge; operand registers change only on IDLE accept.
REQ-023: Unit responses arriving in any state other than the matching WAIT_x SHALL be ignored (corresponding resp_rdy=0).
REQ-024: Minimum latency: accept edge, +1 cycle REQ_x, +1 cycle earliest WAIT_x capture, RESP visible 3 cycles after accept when units respond immediately; illegal fn: RESP 1 cycle after accept.
REQ-025: All outputs SHALL be registered-state-decoded (Moore); no combinational path from any input to muldivreq_rdy or muldivresp_val.

Reset
REQ-026: reset=1 SHALL immediately force IDLE, result register 0, operand registers 0, all val/rdy outputs 0 except muldivreq_rdy=1 after reset deasserts; reset mid-operation abandons it with no response.
REQ-027: mulreq_*, divreq_* outputs SHALL be 0 during and after reset until next dispatch.

Verification
REQ-028: MUL a=7, b=-3 (32'hFFFFFFFD), product 64'hFFFFFFFF_FFFFFFEB -> result 32'hFFFFFFEB, mulreq_val seen one cycle.
REQ-029: DIV a=-7, b=2, divresp {32'hFFFFFFFF, 32'hFFFFFFFD}, divreq_msg_fn=0 -> result 32'hFFFFFFFD; REMU same response -> 32'hFFFFFFFF with divreq_msg_fn=1.
REQ-030: fn=6 -> no unit val asserted, muldivresp_val 1 cycle after accept, result 32'h0.
REQ-031: divreq_rdy held 0 for 5 cycles then 1; muldivresp_rdy held 0 for 3 cycles in RESP -> outputs stable, muldivreq_rdy=0 throughout, single response.
REQ-032: reset asserted asynchronously in WAIT_DIV, divresp_val pulsed after release -> state IDLE, divresp_rdy=0, no muldivresp_val.
REQ-033: back-to-back MUL then DIV with all rdy=1 -> second request accepted only after first response handshake, results in order.
